// File: rtl/ptw_dpath_bcast.sv
// PTW datapath broadcast: registers ptbr/status once and fans them out,
// and runs sfence invalidation rounds across the requestor ports.
module ptw_dpath_bcast #(
  parameter int NREQ     = 2,
  parameter int ASID_W   = 7,
  parameter int PPN_W    = 38,
  parameter int STATUS_W = 99,
  parameter bit AUTO_INV = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ASID_W-1:0]        io_dpath_ptbr_asid,
  input  logic [PPN_W-1:0]         io_dpath_ptbr_ppn,
  input  logic [STATUS_W-1:0]      io_dpath_status,
  input  logic                     io_dpath_invalidate,
  input  logic [NREQ-1:0]          io_dpath_inv_mask,
  output logic                     io_dpath_inv_busy,
  output logic [15:0]              io_dpath_inv_count,
  output logic [NREQ*ASID_W-1:0]   io_requestor_ptbr_asid,
  output logic [NREQ*PPN_W-1:0]    io_requestor_ptbr_ppn,
  output logic [NREQ*STATUS_W-1:0] io_requestor_status,
  output logic [NREQ-1:0]          io_requestor_invalidate,
  input  logic [NREQ-1:0]          io_requestor_inv_ack
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  logic [ASID_W-1:0]   asid_q;
  logic [PPN_W-1:0]    ppn_q;
  logic [STATUS_W-1:0] status_q;
  logic                armed_q;
  state_e              state_q;
  logic [NREQ-1:0]     pend_q;
  logic [15:0]         cnt_q;

  logic            chg;
  logic            trig;
  logic [NREQ-1:0] newp;
  logic [NREQ-1:0] pend_w;

  // armed_q masks the compare while the ptbr registers still hold reset zeros
  assign chg  = (asid_q != io_dpath_ptbr_asid) ||
                (ppn_q != io_dpath_ptbr_ppn);
  assign trig = io_dpath_invalidate ||
                (AUTO_INV && armed_q && chg);
  assign newp = trig ? io_dpath_inv_mask : '0;

  // a fresh trigger re-sets its bits even when acked in the same cycle
  assign pend_w = (pend_q & ~io_requestor_inv_ack) | newp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      asid_q   <= '0;
      ppn_q    <= '0;
      status_q <= '0;
      armed_q  <= 1'b0;
      state_q  <= S_IDLE;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      asid_q   <= io_dpath_ptbr_asid;
      ppn_q    <= io_dpath_ptbr_ppn;
      status_q <= io_dpath_status;
      armed_q  <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (|newp) begin
            pend_q  <= newp;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          pend_q <= pend_w;
          if (~|pend_w) begin
            state_q <= S_IDLE;
            if (~&cnt_q) cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_requestor_ptbr_asid  = {NREQ{asid_q}};
  assign io_requestor_ptbr_ppn   = {NREQ{ppn_q}};
  assign io_requestor_status     = {NREQ{status_q}};
  assign io_requestor_invalidate = pend_q;
  assign io_dpath_inv_busy       = (state_q == S_WAIT);
  assign io_dpath_inv_count      = cnt_q;

endmodule

// File: tb/tb_ptw_dpath_bcast.sv
// Directed bench for ptw_dpath_bcast: broadcast latency, invalidation
// rounds, ack handling, coalescing, reset abort and count saturation.
module tb_ptw_dpath_bcast;

  localparam int NREQ = 2;
  localparam int AW   = 7;
  localparam int PW   = 38;
  localparam int SW   = 99;

  logic                clk = 1'b0;
  logic                reset;
  logic [AW-1:0]       asid;
  logic [PW-1:0]       ppn;
  logic [SW-1:0]       status;
  logic                inv;
  logic [NREQ-1:0]     mask;
  logic                busy;
  logic [15:0]         cnt;
  logic [NREQ*AW-1:0]  rasid;
  logic [NREQ*PW-1:0]  rppn;
  logic [NREQ*SW-1:0]  rstat;
  logic [NREQ-1:0]     rinv;
  logic [NREQ-1:0]     ack;

  int n_vec = 0;
  int n_err = 0;

  logic [SW-1:0] st_pat;

  ptw_dpath_bcast #(
    .NREQ(NREQ), .ASID_W(AW), .PPN_W(PW),
    .STATUS_W(SW), .AUTO_INV(1'b1)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .io_dpath_ptbr_asid      (asid),
    .io_dpath_ptbr_ppn       (ppn),
    .io_dpath_status         (status),
    .io_dpath_invalidate     (inv),
    .io_dpath_inv_mask       (mask),
    .io_dpath_inv_busy       (busy),
    .io_dpath_inv_count      (cnt),
    .io_requestor_ptbr_asid  (rasid),
    .io_requestor_ptbr_ppn   (rppn),
    .io_requestor_status     (rstat),
    .io_requestor_invalidate (rinv),
    .io_requestor_inv_ack    (ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic round(input logic [NREQ-1:0] m);
    inv  = 1'b1;
    mask = m;
    step();
    inv  = 1'b0;
    mask = '0;
    ack  = m;
    step();
    ack  = '0;
  endtask

  initial begin
    st_pat = 99'h5_DEAD_BEEF_0123_4567_89AB_CDEF;
    reset = 1'b0;
    asid = '0; ppn = '0; status = '0;
    inv = 1'b0; mask = '0; ack = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_inv", rinv, 0);
    chk("rst_asid", rasid, 0);
    chk("rst_ppn", rppn, 0);
    chk("rst_stat", rstat, 0);

    // first cycle after release: inputs differ from zeroed regs
    reset = 1'b1;
    asid = 7'h05; ppn = 38'h123; status = st_pat;
    mask = 2'b11;
    step();
    mask = '0;
    chk("bc_asid", rasid, {2{7'h05}});
    chk("bc_ppn", rppn, {2{38'h123}});
    chk("bc_stat", rstat, {2{st_pat}});
    chk("first_busy", busy, 0);
    chk("first_inv", rinv, 0);

    asid = 7'h06;
    chk("lat_hold", rasid, {2{7'h05}});
    step();
    chk("lat_new", rasid, {2{7'h06}});
    chk("lat_busy", busy, 0);

    // reset in the middle of a round
    inv = 1'b1; mask = 2'b11;
    step();
    inv = 1'b0; mask = '0;
    chk("mw_inv", rinv, 2'b11);
    chk("mw_busy", busy, 1);
    reset = 1'b0;
    step();
    chk("ab_inv", rinv, 0);
    chk("ab_busy", busy, 0);
    chk("ab_cnt", cnt, 0);
    chk("ab_asid", rasid, 0);
    reset = 1'b1; mask = 2'b11;
    step();
    mask = '0;
    chk("rel_busy", busy, 0);
    chk("rel_inv", rinv, 0);
    chk("rel_asid", rasid, {2{7'h06}});
    step();
    chk("rel_busy2", busy, 0);

    // two-requestor round, acks at +3 and +5
    inv = 1'b1; mask = 2'b11;
    step();
    inv = 1'b0; mask = '0;
    chk("r2_inv_a", rinv, 2'b11);
    chk("r2_busy_a", busy, 1);
    step();
    ack = 2'b01;
    chk("r2_inv_b", rinv, 2'b11);
    step();
    ack = 2'b01;
    chk("r2_inv_c", rinv, 2'b10);
    step();
    ack = 2'b10;
    chk("r2_stray", rinv, 2'b10);
    chk("r2_busy_c", busy, 1);
    step();
    ack = '0;
    chk("r2_inv_d", rinv, 2'b00);
    chk("r2_busy_d", busy, 0);
    chk("r2_cnt", cnt, 1);

    // ptbr change auto-invalidates masked requestor only
    ppn = 38'h124; mask = 2'b01;
    step();
    mask = '0;
    chk("ai_ppn", rppn, {2{38'h124}});
    chk("ai_inv", rinv, 2'b01);
    chk("ai_cnt0", cnt, 1);
    ack = 2'b01;
    step();
    ack = '0;
    chk("ai_busy", busy, 0);
    chk("ai_cnt", cnt, 2);

    // retrigger coinciding with ack keeps the bit pending
    inv = 1'b1; mask = 2'b01;
    step();
    ack = 2'b01;
    step();
    inv = 1'b0; mask = '0; ack = '0;
    chk("co_inv", rinv, 2'b01);
    chk("co_cnt", cnt, 2);
    step();
    chk("co_hold", rinv, 2'b01);
    ack = 2'b01;
    step();
    ack = '0;
    chk("co_done", rinv, 0);
    chk("co_cnt1", cnt, 3);

    // coalesce a new mask bit into a pending round
    inv = 1'b1; mask = 2'b01;
    step();
    mask = 2'b10;
    step();
    inv = 1'b0; mask = '0;
    chk("or_inv", rinv, 2'b11);
    chk("or_cnt", cnt, 3);
    ack = 2'b11;
    step();
    ack = '0;
    chk("or_cnt1", cnt, 4);

    // trigger with empty mask is a no-op
    inv = 1'b1; mask = '0;
    step();
    inv = 1'b0;
    chk("z_busy", busy, 0);
    chk("z_cnt", cnt, 4);

    // saturation
    force dut.cnt_q = 16'hFFFE;
    step();
    release dut.cnt_q;
    step();
    chk("sat_pre", cnt, 16'hFFFE);
    round(2'b01);
    chk("sat_top", cnt, 16'hFFFF);
    round(2'b10);
    chk("sat_hold", cnt, 16'hFFFF);
    chk("sat_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
